// File: rtl/nes_pad_poller_if.sv
// Console-side bundle for the NES joypad poller: pad wires, poll request and
// the published button byte.
interface nes_pad_poller_if;
   logic       start;
   logic       pad_data_n;
   logic       pad_latch;
   logic       pad_clk;
   logic [7:0] buttons;
   logic       valid;
   logic       busy;

   // master: the pad plus whoever requests polls; slave: the poller itself.
   modport master (
      output start,
      output pad_data_n,
      input  pad_latch,
      input  pad_clk,
      input  buttons,
      input  valid,
      input  busy
   );

   modport slave (
      input  start,
      input  pad_data_n,
      output pad_latch,
      output pad_clk,
      output buttons,
      output valid,
      output busy
   );
endinterface

// File: rtl/nes_pad_poller.sv
// Polls a CD4021-based NES joypad: latch pulse, eight clocked bit reads,
// then publishes an active-high button byte with a one-cycle valid pulse.
module nes_pad_poller #(
   parameter int unsigned LATCH_CYCLES         = 600,
   parameter int unsigned HALF_BIT_CYCLES      = 300,
   parameter int unsigned POLL_INTERVAL_CYCLES = 833333
) (
   input  logic              clk,
   input  logic              reset_n,
   nes_pad_poller_if.slave   bus
);

   localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES
                                                                        : HALF_BIT_CYCLES;
   localparam int unsigned PHASE_W   = $clog2(PHASE_MAX);
   localparam int unsigned INTV_W    = $clog2(POLL_INTERVAL_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_BIT_HIGH,
      S_BIT_LOW,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [PHASE_W-1:0]  r_phase;
   logic [2:0]          r_bit;
   logic [7:0]          r_shift;
   logic [INTV_W-1:0]   r_interval;
   logic                r_sync1;
   logic                r_sync2;
   logic                r_pad_latch;
   logic                r_pad_clk;
   logic [7:0]          r_buttons;
   logic                r_valid;
   logic                r_busy;

   logic                w_auto;
   logic                w_trigger;
   logic                w_latch_end;
   logic                w_half_end;

   assign w_auto      = (r_interval == INTV_W'(POLL_INTERVAL_CYCLES - 1));
   assign w_trigger   = bus.start | w_auto;
   assign w_latch_end = (r_phase == PHASE_W'(LATCH_CYCLES - 1));
   assign w_half_end  = (r_phase == PHASE_W'(HALF_BIT_CYCLES - 1));

   // NOTE: synchronizer resets to 1 so an idle (pulled-up) line reads as "not pressed".
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.pad_data_n;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running poll timer; a manual start re-phases it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_interval <= '0;
      end else if (bus.start || w_auto) begin
         r_interval <= '0;
      end else begin
         r_interval <= r_interval + INTV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_phase     <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_pad_latch <= 1'b0;
         r_pad_clk   <= 1'b1;
         r_buttons   <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_trigger) begin
                  r_state     <= S_LATCH;
                  r_pad_latch <= 1'b1;
                  r_busy      <= 1'b1;
                  r_phase     <= '0;
                  r_bit       <= '0;
                  r_shift     <= '0;
               end
            end
            S_LATCH: begin
               if (w_latch_end) begin
                  r_state     <= S_BIT_HIGH;
                  r_pad_latch <= 1'b0;
                  r_phase     <= '0;
               end else begin
                  r_phase <= r_phase + PHASE_W'(1);
               end
            end
            S_BIT_HIGH: begin
               // Sample at the end of the high phase, when the synchronized bit has settled.
               if (w_half_end) begin
                  r_shift[r_bit] <= ~r_sync2;
                  r_state        <= S_BIT_LOW;
                  r_pad_clk      <= 1'b0;
                  r_phase        <= '0;
               end else begin
                  r_phase <= r_phase + PHASE_W'(1);
               end
            end
            S_BIT_LOW: begin
               if (w_half_end) begin
                  r_pad_clk <= 1'b1;
                  r_phase   <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_DONE;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_state <= S_BIT_HIGH;
                  end
               end else begin
                  r_phase <= r_phase + PHASE_W'(1);
               end
            end
            S_DONE: begin
               r_buttons <= r_shift;
               r_valid   <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.pad_latch = r_pad_latch;
   assign bus.pad_clk   = r_pad_clk;
   assign bus.buttons   = r_buttons;
   assign bus.valid     = r_valid;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller: a 4021 pad model, a trigger-timing reference model
// feeding a scoreboard queue, and a monitor that checks every valid pulse.
module tb_nes_pad_poller;

   localparam int LAT  = 4;
   localparam int HALF = 4;
   localparam int INTV = 200;
   localparam int LATENCY = LAT + 16 * HALF + 1;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   nes_pad_poller_if pif ();

   nes_pad_poller #(
      .LATCH_CYCLES        (LAT),
      .HALF_BIT_CYCLES     (HALF),
      .POLL_INTERVAL_CYCLES(INTV)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (pif.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pad model: 4021 loads on latch, shifts toward bit 0 on pad_clk rise, fills with 1.
   logic [7:0] pad_bits    = 8'hFF;
   logic [7:0] pad_sr      = 8'hFF;
   logic       pad_present = 1'b1;

   always @(posedge pif.pad_clk or posedge pif.pad_latch) begin
      if (pif.pad_latch) pad_sr = pad_bits;
      else               pad_sr = {1'b1, pad_sr[7:1]};
   end
   assign pif.pad_data_n = pad_present ? pad_sr[0] : 1'b1;

   // Reference model: decides from start, timer period and busy window when polls happen.
   typedef struct {
      logic [7:0] buttons;
      int         due;
   } exp_t;
   exp_t exp_q[$];

   int cyc          = 0;
   int m_base       = 0;
   int m_poll_start = -1;
   bit m_auto;

   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         m_base       = cyc;
         m_poll_start = -1;
         exp_q.delete();
      end else begin
         m_auto = ((cyc - m_base) % INTV) == 0;
         if (pif.start || m_auto) m_base = cyc;
         if ((pif.start || m_auto) && (m_poll_start < 0 || cyc >= m_poll_start + LATENCY + 1)) begin
            m_poll_start = cyc;
            exp_q.push_back('{pad_present ? ~pad_bits : 8'h00, cyc + LATENCY});
         end
      end
   end

   // Monitor: samples on the falling edge, pops the scoreboard on every valid.
   logic [7:0] m_buttons   = 8'h00;
   logic       prev_latch  = 1'b0;
   logic       prev_clk    = 1'b1;
   int         latch_run   = 0;
   int         latch_w     = 0;
   int         n_latch     = 0;
   int         lat_rises   = 0;
   int         low_run     = 0;
   int         n_low       = 0;
   int         low_w_bad   = 0;
   bit         exp_busy;
   exp_t       e;

   always @(negedge clk) begin
      if (!reset_n) begin
         check("reset_outputs",
               32'({pif.pad_latch, pif.pad_clk, pif.buttons, pif.valid, pif.busy}),
               32'({1'b0, 1'b1, 8'h00, 1'b0, 1'b0}));
         m_buttons  = 8'h00;
         prev_latch = 1'b0;
         prev_clk   = 1'b1;
         latch_run  = 0;
         n_latch    = 0;
         low_run    = 0;
         n_low      = 0;
         low_w_bad  = 0;
      end else begin
         exp_busy = (m_poll_start >= 0) && (cyc < m_poll_start + LATENCY);
         if (pif.pad_latch) begin
            if (!prev_latch) lat_rises++;
            latch_run++;
         end else if (prev_latch) begin
            n_latch++;
            latch_w   = latch_run;
            latch_run = 0;
         end
         if (!pif.pad_clk) begin
            low_run++;
         end else if (!prev_clk) begin
            n_low++;
            if (low_run != HALF) low_w_bad++;
            low_run = 0;
         end
         prev_latch = pif.pad_latch;
         prev_clk   = pif.pad_clk;

         check("busy", 32'(pif.busy), 32'(exp_busy));
         if (!exp_busy) check("idle_lines", 32'({pif.pad_latch, pif.pad_clk}), 32'b01);

         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("missing_valid", cyc, exp_q[0].due);
            void'(exp_q.pop_front());
         end

         if (pif.valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 32'(pif.valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("buttons", 32'(pif.buttons), 32'(e.buttons));
               check("valid_cycle", cyc, e.due);
               check("latch_count", n_latch, 1);
               check("latch_width", latch_w, LAT);
               check("clk_pulses", n_low, 8);
               check("clk_width_errs", low_w_bad, 0);
               m_buttons = e.buttons;
            end
            n_latch   = 0;
            n_low     = 0;
            low_w_bad = 0;
         end else begin
            check("buttons_hold", 32'(pif.buttons), 32'(m_buttons));
         end
      end
   end

   // Stimulus helpers: all run in the "2 ns after rising edge" phase.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_start(output int t);
      pif.start = 1'b1;
      @(posedge clk);
      #1 t = cyc;
      #1 pif.start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (pif.valid) begin
            at = cyc;
            break;
         end
      end
   endtask

   int t0, t1, tv, tv1, tv2, tx, n;

   initial begin
      pif.start = 1'b0;
      reset_n   = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b1;

      idle(150);
      check("quiet_after_reset", lat_rises, 0);

      // Manual poll: A, Start, Left pressed.
      pad_bits = 8'hB6;
      pulse_start(t0);
      wait_valid(120, tv);
      check("manual_latency", tv - t0, LATENCY);
      check("manual_buttons", 32'(pif.buttons), 32'h49);

      // Auto polls: Right + B pressed; timer re-phased by the start above.
      pad_bits = 8'h7D;
      wait_valid(300, tv1);
      check("auto_first", tv1 - t0, INTV + LATENCY);
      check("auto_buttons", 32'(pif.buttons), 32'h82);
      wait_valid(300, tv2);
      check("auto_period", tv2 - tv1, INTV);

      // Dropped trigger: second start 10 cycles into an active poll.
      pulse_start(t1);
      idle(9);
      pulse_start(tx);
      wait_valid(120, tv);
      check("dropped_latency", tv - t1, LATENCY);
      wait_valid(100, tx);
      check("no_second_poll", tx, -1);

      // Random pad states, random manual starts mixed with auto polls.
      for (int i = 0; i < 8; i++) begin
         idle($urandom_range(0, 150));
         pad_bits = 8'($urandom);
         if ($urandom_range(0, 1) == 1) pulse_start(tx);
      end
      idle(300);

      // Reset during the low phase of bit 3.
      n = 0;
      while (pif.busy && n < 200) begin
         idle(1);
         n++;
      end
      pad_bits = 8'h5A;
      pulse_start(t1);
      idle(33);
      check("pre_reset_clk_low", 32'(pif.pad_clk), 32'd0);
      reset_n = 1'b0;
      #1;
      check("reset_clk_high", 32'(pif.pad_clk), 32'd1);
      check("reset_buttons", 32'(pif.buttons), 32'h00);
      #1;
      idle(3);
      reset_n  = 1'b1;
      pad_bits = 8'hC3;
      pulse_start(t1);
      wait_valid(120, tv);
      check("post_reset_latency", tv - t1, LATENCY);
      check("post_reset_buttons", 32'(pif.buttons), 32'h3C);

      // Pad absent: line floats high, all buttons released.
      pad_present = 1'b0;
      pulse_start(t1);
      wait_valid(120, tv);
      check("nopad_latency", tv - t1, LATENCY);
      check("nopad_buttons", 32'(pif.buttons), 32'h00);

      // Start in the same cycle as the timer wrap.
      idle(t1 + INTV - 1 - cyc);
      n = lat_rises;
      pulse_start(tx);
      idle(150);
      check("simultaneous_one_poll", lat_rises - n, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
